// File: rtl/oisc_pkg.sv
// Shared definitions for the SUBLEQ datapath: default widths, address-select
// encodings and the read-tag that tracks what sram_rdata currently holds.
package oisc_pkg;

  localparam int DATA_W_DFLT = 16;
  localparam int ADDR_W_DFLT = 8;

  localparam logic [1:0] ADDR_PC = 2'b00;
  localparam logic [1:0] ADDR_A  = 2'b01;
  localparam logic [1:0] ADDR_B  = 2'b10;
  localparam logic [1:0] ADDR_C  = 2'b11;

  // Low two bits mirror addr_sel of the read that produced sram_rdata.
  typedef enum logic [2:0] {
    RD_TAG_PC   = 3'b000,
    RD_TAG_A    = 3'b001,
    RD_TAG_B    = 3'b010,
    RD_TAG_C    = 3'b011,
    RD_TAG_NONE = 3'b100
  } rd_tag_e;

endpackage

// File: rtl/oisc_datapath_if.sv
// Control-path / SRAM side of the SUBLEQ datapath. The master is the
// sequencing FSM plus SRAM read data; the slave is the datapath itself.
interface oisc_datapath_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              sram_en;
  logic              sram_we;
  logic [1:0]        addr_sel;
  logic              en_a;
  logic              en_b_addr;
  logic              pc_inc;
  logic              pc_br;
  logic [DATA_W-1:0] sram_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              leq;
  logic              a_vs_b;
  logic [ADDR_W-1:0] pc_dbg;

  modport master (
    output sram_en, sram_we, addr_sel, en_a, en_b_addr, pc_inc, pc_br, sram_rdata,
    input  sram_addr, sram_wdata, leq, a_vs_b, pc_dbg
  );

  modport slave (
    input  sram_en, sram_we, addr_sel, en_a, en_b_addr, pc_inc, pc_br, sram_rdata,
    output sram_addr, sram_wdata, leq, a_vs_b, pc_dbg
  );
endinterface

// File: rtl/oisc_sub_cmp.sv
// Two's-complement subtractor with a signed "result <= 0" detect.
module oisc_sub_cmp #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] minuend,
  input  logic [DATA_W-1:0] subtrahend,
  output logic [DATA_W-1:0] diff,
  output logic              le_zero
);

  assign diff    = minuend - subtrahend;
  assign le_zero = diff[DATA_W-1] | (diff == '0);

endmodule

// File: rtl/oisc_datapath.sv
// SUBLEQ datapath: PC, operand/address registers, read-tag pipeline and
// subtractor. All sequencing comes from the external control FSM.
module oisc_datapath
  import oisc_pkg::*;
#(
  parameter int                DATA_W = DATA_W_DFLT,
  parameter int                ADDR_W = ADDR_W_DFLT,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input logic             clk,
  input logic             rstn,
  oisc_datapath_if.slave  bus
);

  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [DATA_W-1:0] reg_a_q,  reg_a_d;
  logic [ADDR_W-1:0] reg_b_q,  reg_b_d;
  logic [DATA_W-1:0] diff_q,   diff_d;
  logic              leq_q,    leq_d;
  rd_tag_e           rd_tag_q, rd_tag_d;

  logic [DATA_W-1:0] sub_diff;
  logic              sub_le;
  logic              ab_match;

  oisc_sub_cmp #(.DATA_W(DATA_W)) u_sub_cmp (
    .minuend    (bus.sram_rdata),
    .subtrahend (reg_a_q),
    .diff       (sub_diff),
    .le_zero    (sub_le)
  );

  // A B-address equal to A's address means mem[B]-mem[A] is 0 without reading B.
  assign ab_match = bus.en_b_addr && (bus.sram_rdata[ADDR_W-1:0] == reg_a_q[ADDR_W-1:0]);

  always_comb begin
    rd_tag_d = (bus.sram_en && !bus.sram_we) ? rd_tag_e'({1'b0, bus.addr_sel}) : RD_TAG_NONE;
    reg_a_d  = bus.en_a      ? bus.sram_rdata               : reg_a_q;
    reg_b_d  = bus.en_b_addr ? bus.sram_rdata[ADDR_W-1:0]   : reg_b_q;

    diff_d = diff_q;
    leq_d  = leq_q;
    if (rd_tag_q == RD_TAG_B) begin
      diff_d = sub_diff;
      leq_d  = sub_le;
    end else if (ab_match) begin
      diff_d = '0;
      leq_d  = 1'b1;
    end

    pc_d = pc_q;
    if (bus.pc_br) begin
      pc_d = bus.sram_rdata[ADDR_W-1:0];
    end else if (bus.pc_inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= RST_PC;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      diff_q   <= '0;
      leq_q    <= 1'b0;
      rd_tag_q <= RD_TAG_NONE;
    end else begin
      pc_q     <= pc_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      diff_q   <= diff_d;
      leq_q    <= leq_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  always_comb begin
    bus.sram_addr = pc_q;
    case (bus.addr_sel)
      ADDR_A:  bus.sram_addr = reg_a_q[ADDR_W-1:0];
      ADDR_B:  bus.sram_addr = reg_b_q;
      default: bus.sram_addr = pc_q;
    endcase
  end

  assign bus.sram_wdata = diff_q;
  assign bus.leq        = leq_q;
  assign bus.a_vs_b     = (reg_a_q[ADDR_W-1:0] == reg_b_q);
  assign bus.pc_dbg     = pc_q;

endmodule

// File: doc/oisc_datapath.md
Name: oisc_datapath

Overview:
- Datapath for the SUBLEQ one-instruction processor.
- Consumes the control strobes produced by the processor FSM and drives the shared single-port SRAM address/write-data lines.
- Holds PC, operand and address registers plus the subtractor.
- Returns the status flags `leq` and `a_vs_b` to the FSM.
- Instruction = three consecutive words at PC, PC+1, PC+2 holding A, B, C; semantics mem[B] <= mem[B] - mem[A]; if result <= 0 then PC <= C, else PC <= PC+3.

Parameters:
- DATA_W, 16, SRAM word width; also the arithmetic width.
- ADDR_W, 8, SRAM address width; PC width.
- RST_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- sram_en  in  1  FSM: SRAM access this cycle.
- sram_we  in  1  FSM: access is a write.
- addr_sel  in  2  FSM: address source. 00 = PC, 01 = reg_a, 10 = reg_b, 11 = PC (C-field fetch, tagged).
- en_a  in  1  FSM: load reg_a from sram_rdata.
- en_b_addr  in  1  FSM: load reg_b from sram_rdata.
- pc_inc  in  1  FSM: PC <= PC+1.
- pc_br  in  1  FSM: PC <= sram_rdata[ADDR_W-1:0].
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read request.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- leq  out  1  registered: last subtraction result <= 0 (signed).
- a_vs_b  out  1  combinational: reg_a[ADDR_W-1:0] == reg_b.
- pc_dbg  out  ADDR_W  current PC, for bench observation.

Behaviour:
- Reset (rstn=0, asynchronous): pc=RST_PC; reg_a=0, reg_b=0, diff=0, leq=0, rd_tag=NONE. Outputs follow (sram_addr=RST_PC, a_vs_b=1). Reset mid-instruction abandons it; no SRAM write is issued while rstn=0.
- Address mux (combinational):
  - sram_addr = pc for sel 00/11, reg_a[ADDR_W-1:0] for 01, reg_b for 10.
  - Width truncation of reg_a is silent.
- Read-tag pipeline: on each clk, rd_tag <= (sram_en & ~sram_we) ? addr_sel : NONE. rd_tag therefore identifies what sram_rdata holds this cycle.
- reg_a: loads sram_rdata when en_a=1. It holds the A address first, and is reloaded with mem[A] on a later en_a.
- reg_b: loads sram_rdata[ADDR_W-1:0] when en_b_addr=1.
- Subtractor:
  - When rd_tag == 10 (mem[B] returning), diff <= sram_rdata - reg_a, modulo 2^DATA_W, two's complement.
  - In the same edge, leq <= diff_next[DATA_W-1] | (diff_next == 0).
  - diff and leq hold otherwise.
- Write data: sram_wdata = diff at all times. The write is performed by the FSM asserting sram_en & sram_we with addr_sel = 10, one or more cycles after the B read.
- PC:
  - pc_br has priority over pc_inc.
  - pc_inc: pc <= pc+1, wrapping from 2^ADDR_W-1 to 0.
  - pc_br: pc <= sram_rdata[ADDR_W-1:0]. It is legal only when rd_tag == 11; otherwise it is a protocol error and still loads.
  - Neither asserted: pc holds.
- Simultaneous events:
  - en_a & en_b_addr in the same cycle: both load the same rdata.
  - A write cycle forces rd_tag = NONE, so diff is not disturbed.
- a_vs_b compares the current register values, with no latency. The FSM uses it to skip the redundant B-operand read when A == B, in which case the result is 0 and leq = 1.
- A == B path: when the FSM skips the read, diff must read 0. On any edge where en_b_addr loads a value equal to reg_a's address, diff <= 0 and leq <= 1.
- No internal FSM; all sequencing is owned by the control path.

Decomposition:
- Shared package oisc_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the addr_sel encodings ADDR_PC=2'b00, ADDR_A=2'b01, ADDR_B=2'b10, ADDR_C=2'b11;
  - RD_TAG_NONE.
- One natural sub-module: oisc_sub_cmp, the DATA_W subtractor plus <=0 detect, purely combinational, instantiated once.
- Registers stay in oisc_datapath.

Test Plan:
- Reset: assert rstn=0 mid-run with pc=0x37 -> pc_dbg=0x00, leq=0, sram_addr=0x00 immediately, without waiting for clk.
- Non-branch: mem[A]=5, mem[B]=9 -> sram_wdata=4, leq=0; pc_inc x3 from 0x10 -> pc_dbg=0x13.
- Branch on zero: mem[A]=7, mem[B]=7, C=0x40 -> diff=0, leq=1; pc_br on C fetch -> pc_dbg=0x40.
- Negative/wrap: mem[A]=1, mem[B]=0x8000 -> diff=0x7FFF, leq=0. mem[A]=1, mem[B]=0 -> diff=0xFFFF, leq=1.
- A==B: reg_a=0x22, load reg_b=0x22 -> a_vs_b=1 same cycle; next edge diff=0, leq=1.
- PC wrap and priority: pc=0xFF with pc_inc -> 0x00. pc_inc and pc_br together with rdata=0x5A -> pc=0x5A.
